temp_display: RTL and testbench
===============================

TEMP_DISPLAY -- requirements
Module: temp_display

Interface
REQ-001 Parameter SCAN_DIV, default 1, is the number of CLK_IN cycles per display digit slot; legal range is 1..65535.
REQ-002 CLK_IN  input  1  single system clock (1 kHz nominal); all logic is on the rising edge.
REQ-003 CLR  input  1  reset, synchronous and active-high.
REQ-004 TEMP  input  8  two's-complement whole degrees Celsius from the DS1620 interface stage; it may change on any cycle.
REQ-005 SEG  output  7  registered segment drive {g,f,e,d,c,b,a}, active-high.
REQ-006 AN  output  4  registered digit enables, active-low, one-hot; AN[0] is ones, AN[1] tens, AN[2] hundreds, AN[3] sign.
REQ-007 BUSY  output  1  registered; high while a conversion is in progress.
REQ-008 RANGE_ERR  output  1  registered; high while the displayed value is out of range.

Function
REQ-009 The block SHALL hold a captured value CAP (8 bits); a conversion SHALL start when state=IDLE and TEMP != CAP.
REQ-010 FSM states: IDLE, LOAD, SHIFT, DONE. IDLE->LOAD on the start condition. LOAD->SHIFT after 1 cycle. SHIFT->DONE after exactly 8 cycles. DONE->IDLE after 1 cycle.
REQ-011 LOAD SHALL copy TEMP into CAP, record sign=TEMP[7], and form magnitude = TEMP[7] ? (~TEMP+1) : TEMP, 8-bit unsigned (0x80 gives 128).
REQ-012 SHIFT SHALL perform sequential double-dabble: per cycle, each BCD nibble >=5 gets +3, then {BCD[11:0], mag} is shifted left 1 bit; there SHALL be exactly 8 iterations.
REQ-013 DONE SHALL update the display registers (sign, hundreds, tens, ones, RANGE_ERR) atomically in one cycle; they SHALL NOT change at any other time except reset.
REQ-014 The value is in range only if -55 <= CAP <= +125; otherwise RANGE_ERR=1 and the digits SHALL show sign=blank, hundreds='E', tens='r', ones='r'.
REQ-015 Latency: the start condition is seen at edge N, and the display registers are updated at edge N+10; BUSY=1 from edge N+1 through edge N+10, and is 0 otherwise.
REQ-016 TEMP changes during LOAD/SHIFT/DONE SHALL be ignored; after returning to IDLE, if TEMP != CAP a new conversion starts at the next edge, so the last value always wins.
REQ-017 Blanking: the sign digit shows '-' when negative and blank otherwise; hundreds is blank when 0; tens is blank when hundreds=0 and tens=0; ones is always shown.
REQ-018 Segment codes (hex, gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, '-'=40, blank=00, 'E'=79, 'r'=50.
REQ-019 Scan: a divider counts 0..SCAN_DIV-1. On wrap (the scan tick), digit index IDX increments modulo 4 (3->0), and AN/SEG are loaded in the same edge for the new IDX.
REQ-020 AN SHALL be ~(4'b0001 << IDX), and SEG SHALL be the code for digit IDX taken from the display registers.
REQ-021 Scanning SHALL run continuously and independently of the FSM; a DONE update is reflected at the next scan tick for each digit.

Reset
REQ-022 With CLR=1 at an edge: state=IDLE, CAP=0x00, display registers set to "   0" (sign blank, hundreds blank, tens blank, ones 0), RANGE_ERR=0, BUSY=0, divider=0, IDX=3, AN=4'b1111, SEG=7'h00.
REQ-023 CLR SHALL override everything, including a conversion in progress; a partial result SHALL NOT reach the display registers.
REQ-024 After CLR falls, with SCAN_DIV=1, the first edge gives IDX=0, AN=1110, SEG=3F; if TEMP != 0x00 a conversion starts at that same edge.

Verification
REQ-025 Reset: CLR=1 for 1 cycle, TEMP=0x00 -> AN=1111 and SEG=00 during reset; afterwards AN cycles 1110,1101,1011,0111 with SEG 3F,00,00,00; BUSY stays 0.
REQ-026 Positive: TEMP=0x19 (25) -> BUSY high for 10 cycles, then the scan shows ones=6D, tens=5B, hundreds=00, sign=00, RANGE_ERR=0.
REQ-027 Negative/boundary: TEMP=0xC9 (-55) -> scan shows 6D, 6D, 00, 40; TEMP=0x7D (125) -> 6D, 5B, 06, 00; TEMP=0x00 -> 3F, 00, 00, 00.
REQ-028 Range: TEMP=0x7E (126) -> RANGE_ERR=1 and scan shows 50, 50, 79, 00; TEMP=0x80 (-128) -> the same; a following TEMP=0x05 -> RANGE_ERR=0 and scan shows 6D, 00, 00, 00.
REQ-029 Mid-conversion change: TEMP goes 0x0A->0x14 at SHIFT cycle 3 -> first the display shows 10, then a second conversion starts on the edge after DONE and the display ends at 20; the checker confirms no intermediate value appears.
REQ-030 Reset mid-operation: CLR=1 during SHIFT with TEMP=0x63 -> after reset the display shows "   0", then a fresh conversion gives 99 (scan 6F, 6F, 00, 00) 10 cycles after CLR falls.

Source files
------------

// File: rtl/temp_display.sv
// Signed-temperature to four-digit multiplexed seven-segment display driver.
// A conversion FSM runs sequential double-dabble; a free-running scanner drives the digits.
module temp_display #(
    parameter int unsigned SCAN_DIV = 1
) (
    input  logic       CLK_IN,
    input  logic       CLR,
    input  logic [7:0] TEMP,
    output logic [6:0] SEG,
    output logic [3:0] AN,
    output logic       BUSY,
    output logic       RANGE_ERR
);

    localparam int unsigned DIV_W   = 16;
    localparam int unsigned BCD_W   = 12;
    localparam int unsigned MAG_W   = 8;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned SHIFT_N = 8;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [2:0]       SHIFT_END = 3'(SHIFT_N - 1);

    localparam logic signed [7:0] T_MIN = -8'sd55;
    localparam logic signed [7:0] T_MAX = 8'sd125;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_R     = 7'h50;
    localparam logic [SEG_W-1:0] SEG_ZERO  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]       cap;
    logic             sign;
    logic [MAG_W-1:0] mag;
    logic [BCD_W-1:0] bcd;
    logic [2:0]       bit_cnt;

    logic [SEG_W-1:0] disp_sign;
    logic [SEG_W-1:0] disp_hun;
    logic [SEG_W-1:0] disp_ten;
    logic [SEG_W-1:0] disp_one;

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       idx;

    logic             start_c;
    logic             in_range_c;
    logic [BCD_W-1:0] bcd_adj_c;
    logic [1:0]       idx_next_c;
    logic [SEG_W-1:0] seg_next_c;

    function automatic logic [SEG_W-1:0] digit_code(input logic [3:0] d);
        logic [SEG_W-1:0] code;
        case (d)
            4'd0:    code = 7'h3F;
            4'd1:    code = 7'h06;
            4'd2:    code = 7'h5B;
            4'd3:    code = 7'h4F;
            4'd4:    code = 7'h66;
            4'd5:    code = 7'h6D;
            4'd6:    code = 7'h7D;
            4'd7:    code = 7'h07;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h6F;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] dabble(input logic [3:0] n);
        return (n >= 4'd5) ? 4'(n + 4'd3) : n;
    endfunction

    assign start_c    = (TEMP != cap);
    assign in_range_c = ($signed(cap) >= T_MIN) && ($signed(cap) <= T_MAX);
    assign bcd_adj_c  = {dabble(bcd[11:8]), dabble(bcd[7:4]), dabble(bcd[3:0])};

    // Conversion state register
    always_ff @(posedge CLK_IN) begin
        if (CLR) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Conversion next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_c) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (bit_cnt == SHIFT_END) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture, double-dabble datapath and atomic display update
    always_ff @(posedge CLK_IN) begin
        if (CLR) begin
            cap       <= 8'h00;
            sign      <= 1'b0;
            mag       <= '0;
            bcd       <= '0;
            bit_cnt   <= '0;
            BUSY      <= 1'b0;
            RANGE_ERR <= 1'b0;
            disp_sign <= SEG_BLANK;
            disp_hun  <= SEG_BLANK;
            disp_ten  <= SEG_BLANK;
            disp_one  <= SEG_ZERO;
        end else begin
            BUSY <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    // Capture on the start edge so later TEMP changes cannot leak in
                    if (start_c) begin
                        cap     <= TEMP;
                        sign    <= TEMP[7];
                        mag     <= TEMP[7] ? 8'(~TEMP + 8'd1) : TEMP;
                        bcd     <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    {bcd, mag} <= {bcd_adj_c, mag} << 1;
                    bit_cnt    <= 3'(bit_cnt + 3'd1);
                end
                DONE: begin
                    if (in_range_c) begin
                        RANGE_ERR <= 1'b0;
                        disp_sign <= sign ? SEG_DASH : SEG_BLANK;
                        disp_hun  <= (bcd[11:8] == 4'd0) ? SEG_BLANK : digit_code(bcd[11:8]);
                        disp_ten  <= (bcd[11:4] == 8'd0) ? SEG_BLANK : digit_code(bcd[7:4]);
                        disp_one  <= digit_code(bcd[3:0]);
                    end else begin
                        RANGE_ERR <= 1'b1;
                        disp_sign <= SEG_BLANK;
                        disp_hun  <= SEG_E;
                        disp_ten  <= SEG_R;
                        disp_one  <= SEG_R;
                    end
                end
                default: ;
            endcase
        end
    end

    assign idx_next_c = 2'(idx + 2'd1);

    always_comb begin
        seg_next_c = SEG_BLANK;
        case (idx_next_c)
            2'd0:    seg_next_c = disp_one;
            2'd1:    seg_next_c = disp_ten;
            2'd2:    seg_next_c = disp_hun;
            default: seg_next_c = disp_sign;
        endcase
    end

    // Digit scanner, independent of the conversion FSM
    always_ff @(posedge CLK_IN) begin
        if (CLR) begin
            div_cnt <= '0;
            idx     <= 2'd3;
            AN      <= 4'b1111;
            SEG     <= SEG_BLANK;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            idx     <= idx_next_c;
            AN      <= ~(4'b0001 << idx_next_c);
            SEG     <= seg_next_c;
        end else begin
            div_cnt <= DIV_W'(div_cnt + 1'b1);
        end
    end

endmodule

// File: tb/tb_temp_display.sv
// Directed bench for temp_display: expected displays are queued per conversion and
// the scanned digits are checked against a local digit-index model every cycle.
module tb_temp_display;

    localparam logic [6:0] S_BLANK = 7'h00;
    localparam logic [6:0] S_DASH  = 7'h40;
    localparam logic [6:0] S_E     = 7'h79;
    localparam logic [6:0] S_R     = 7'h50;

    typedef struct packed {
        logic            rerr;
        logic [3:0][6:0] seg;
    } exp_t;

    logic       CLK_IN = 1'b0;
    logic       CLR;
    logic [7:0] TEMP;
    logic [6:0] SEG;
    logic [3:0] AN;
    logic       BUSY;
    logic       RANGE_ERR;

    int   compared   = 0;
    int   mismatched = 0;
    int   idx_m      = 3;
    exp_t sb[$];
    exp_t cur;

    temp_display #(.SCAN_DIV(1)) dut (
        .CLK_IN   (CLK_IN),
        .CLR      (CLR),
        .TEMP     (TEMP),
        .SEG      (SEG),
        .AN       (AN),
        .BUSY     (BUSY),
        .RANGE_ERR(RANGE_ERR)
    );

    always #5 CLK_IN = ~CLK_IN;

    always @(posedge CLK_IN) idx_m <= CLR ? 3 : (idx_m + 1) % 4;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] dcode(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic exp_t model(input logic [7:0] t);
        exp_t e;
        int v, m, h, te, o;
        v = int'($signed(t));
        e.rerr = (v < -55) || (v > 125);
        if (e.rerr) begin
            e.seg[3] = S_BLANK;
            e.seg[2] = S_E;
            e.seg[1] = S_R;
            e.seg[0] = S_R;
        end else begin
            m  = (v < 0) ? -v : v;
            h  = m / 100;
            te = (m / 10) % 10;
            o  = m % 10;
            e.seg[3] = (v < 0) ? S_DASH : S_BLANK;
            e.seg[2] = (h == 0) ? S_BLANK : dcode(h);
            e.seg[1] = (h == 0 && te == 0) ? S_BLANK : dcode(te);
            e.seg[0] = dcode(o);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scan_now();
        logic [3:0] exp_an;
        exp_an = ~(4'b0001 << idx_m);
        chk("an", 32'(AN), 32'(exp_an));
        chk("seg", 32'(SEG), 32'(cur.seg[idx_m]));
    endtask

    task automatic scan_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK_IN);
            scan_now();
            chk("busy_idle", 32'(BUSY), 32'd0);
        end
    endtask

    task automatic start_conv(input logic [7:0] val);
        @(negedge CLK_IN);
        scan_now();
        TEMP = val;
        sb.push_back(model(val));
    endtask

    // Waits out one conversion, optionally changing TEMP after change_at busy samples
    task automatic finish_conv(input int change_at, input logic [7:0] val2);
        int   cnt;
        exp_t e;
        cnt = 0;
        for (int i = 0; i < 4 && cnt == 0; i++) begin
            @(negedge CLK_IN);
            scan_now();
            if (BUSY) cnt = 1;
        end
        chk("busy_rise", 32'(cnt), 32'd1);
        if (cnt == 0) return;
        while (cnt < 20) begin
            if (cnt == change_at) begin
                TEMP = val2;
                sb.push_back(model(val2));
            end
            @(negedge CLK_IN);
            scan_now();
            if (BUSY) cnt++;
            else break;
        end
        chk("busy_len", 32'(cnt), 32'd10);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("range_err", 32'(RANGE_ERR), 32'(e.rerr));
        cur = e;
    endtask

    task automatic conv(input logic [7:0] val);
        start_conv(val);
        finish_conv(0, 8'h00);
        scan_cycles(4);
    endtask

    initial begin
        CLR  = 1'b1;
        TEMP = 8'h00;
        cur  = model(8'h00);
        repeat (2) @(negedge CLK_IN);
        chk("rst_an", 32'(AN), 32'hF);
        chk("rst_seg", 32'(SEG), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_rerr", 32'(RANGE_ERR), 32'd0);
        CLR = 1'b0;
        scan_cycles(8);

        conv(8'h19);
        conv(8'hC9);
        conv(8'h7D);
        conv(8'h00);
        conv(8'h7E);
        conv(8'h80);
        conv(8'h05);

        // Last value wins: TEMP changes in the middle of SHIFT
        start_conv(8'h0A);
        finish_conv(4, 8'h14);
        finish_conv(0, 8'h00);
        scan_cycles(4);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Reset in the middle of a conversion
        @(negedge CLK_IN);
        scan_now();
        TEMP = 8'h63;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK_IN);
            scan_now();
        end
        chk("busy_mid", 32'(BUSY), 32'd1);
        CLR = 1'b1;
        @(negedge CLK_IN);
        chk("rst2_an", 32'(AN), 32'hF);
        chk("rst2_seg", 32'(SEG), 32'h0);
        chk("rst2_busy", 32'(BUSY), 32'd0);
        chk("rst2_rerr", 32'(RANGE_ERR), 32'd0);
        cur = model(8'h00);
        CLR = 1'b0;
        sb.push_back(model(8'h63));
        finish_conv(0, 8'h00);
        scan_cycles(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
